// File: rtl/decrypt_engine.sv
// Byte-stream decrypter: undoes the encrypter's per-bit permutation and rolling 3-key XOR.
// Two-stage valid/ready pipeline with a small register-mapped key/permutation config port.
module decrypt_engine #(
   parameter int          DATA_W   = 8,   // only 8 is meaningful: the permutation has 3-bit entries
   parameter logic [7:0]  DEF_K1   = 8'hDE,
   parameter logic [7:0]  DEF_K2   = 8'hAD,
   parameter logic [7:0]  DEF_K3   = 8'hBE,
   parameter logic [23:0] DEF_PERM = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              config_mode,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [7:0]        cfg_data,
   output logic              cfg_busy,
   output logic              perm_err,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [7:0] DEF_KEY [3] = '{DEF_K1, DEF_K2, DEF_K3};

   logic [7:0] key_q  [3];
   logic [7:0] key_d  [3];
   logic [2:0] perm_q [8];
   logic [2:0] perm_d [8];
   logic       perm_err_q, perm_err_d;
   logic [1:0] idx_q, idx_d;

   logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;

   logic              s1_adv, in_fire, cfg_wr, perm_dup;
   logic [7:0]        key_sel;
   logic [2:0]        perm_use [8];
   logic [DATA_W-1:0] dec;

   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign cfg_busy = s1_valid_q || s2_valid_q || in_fire;
   assign cfg_wr   = cfg_we && !cfg_busy;

   assign perm_err  = perm_err_q;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_last  = s2_last_q;

   // Addresses 11-15 match no entry, so those writes fall through untouched.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         key_d[i] = key_q[i];
         if (cfg_wr && cfg_addr == 4'(i)) key_d[i] = cfg_data;
      end
      for (int i = 0; i < 8; i++) begin
         perm_d[i] = perm_q[i];
         if (cfg_wr && cfg_addr == 4'(i + 3)) perm_d[i] = cfg_data[2:0];
      end
   end

   always_comb begin
      perm_dup = 1'b0;
      for (int i = 0; i < 8; i++)
         for (int j = i + 1; j < 8; j++)
            if (perm_q[i] == perm_q[j]) perm_dup = 1'b1;
      perm_err_d = perm_dup;
   end

   always_comb begin
      case (idx_q)
         2'd1:    key_sel = config_mode ? key_q[1] : DEF_KEY[1];
         2'd2:    key_sel = config_mode ? key_q[2] : DEF_KEY[2];
         default: key_sel = config_mode ? key_q[0] : DEF_KEY[0];
      endcase
   end

   // A broken programmed permutation falls back to the default rather than corrupting data.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_perm_sel
         assign perm_use[gi] = (config_mode && !perm_err_q) ? perm_q[gi] : DEF_PERM[3*gi +: 3];
      end
   endgenerate

   always_comb begin
      dec = '0;
      for (int j = 0; j < 8; j++) dec[perm_use[j]] = s1_data_q[j];
   end

   always_comb begin
      idx_d      = idx_q;
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_last_d  = s1_last_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;
      if (in_fire) idx_d = (in_last || idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = dec;
            s2_last_d = s1_last_q;
         end
         s1_valid_d = 1'b0;
      end
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_data_d  = in_data ^ key_sel;
         s1_last_d  = in_last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) key_q[i] <= DEF_KEY[i];
         for (int i = 0; i < 8; i++) perm_q[i] <= DEF_PERM[3*i +: 3];
         perm_err_q <= 1'b0;
         idx_q      <= 2'd0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) key_q[i] <= key_d[i];
         for (int i = 0; i < 8; i++) perm_q[i] <= perm_d[i];
         perm_err_q <= perm_err_d;
         idx_q      <= idx_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
      end
   end

endmodule
